// File: rtl/m2s_pkg.sv
// Shared constants and types for the m2s request arbiter.
// Holds the 64-bit request field bounds, the identification width and the
// drain state encoding used by m2s_req_arbiter.
package m2s_pkg;

   localparam int unsigned REQ_W   = 64;
   localparam int unsigned RW_BIT  = 63;
   localparam int unsigned ADDR_HI = 62;
   localparam int unsigned ADDR_LO = 32;
   localparam int unsigned DATA_HI = 31;
   localparam int unsigned ID_W    = 10;
   localparam int unsigned CNT_W   = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      DRAIN   = 2'd1,
      DRAINED = 2'd2
   } state_t;

   // One request as seen on the VPI port: {rw_flag, address, data}.
   typedef struct packed {
      logic                       rw;
      logic [ADDR_HI-ADDR_LO:0]   addr;
      logic [DATA_HI:0]           data;
   } m2s_req_t;

endpackage

// File: rtl/m2s_req_arbiter_if.sv
// Bus bundle between the core-side requesters / VPI port and the arbiter.
// slave  : the arbiter's view (takes requests and responses, drives grants,
//          issued accesses, completions and status).
// master : the environment's view (the mirror image).
interface m2s_req_arbiter_if
   import m2s_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 10
);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*REQ_W-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     mem_busy;
   logic                     access_en;
   logic [REQ_W-1:0]         request_out;
   logic [ID_W-1:0]          identification_out;
   logic                     resp_valid;
   logic [ID_W-1:0]          resp_id;
   logic [DATA_HI:0]         resp_data;
   logic [NUM_REQ-1:0]       cmp_valid;
   logic [DATA_HI:0]         cmp_data;
   logic [CNT_W-1:0]         outstanding;
   logic                     drain_req;
   logic                     drained;
   logic                     orphan_resp;

   modport slave (
      input  req_valid, req_data, mem_busy, resp_valid, resp_id, resp_data, drain_req,
      output req_ready, access_en, request_out, identification_out,
             cmp_valid, cmp_data, outstanding, drained, orphan_resp
   );

   modport master (
      output req_valid, req_data, mem_busy, resp_valid, resp_id, resp_data, drain_req,
      input  req_ready, access_en, request_out, identification_out,
             cmp_valid, cmp_data, outstanding, drained, orphan_resp
   );

endinterface

// File: rtl/m2s_rr_arbiter.sv
// Round-robin arbiter with a rotating start pointer.
// Ports: clk, reset (async, active-high); en gates any grant; req is the
// per-requester valid vector; grant_c is the one-hot winner and grant_idx_c
// its index (both combinational). The pointer moves past the winner on grant.
module m2s_rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant_c,
   output logic [$clog2(NUM_REQ)-1:0] grant_idx_c
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] idx_c;
   logic             found_c;

   // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant_c     = '0;
      grant_idx_c = '0;
      found_c     = 1'b0;
      idx_c       = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         idx_c = PTR_W'((int'(ptr_q) + k) % int'(NUM_REQ));
         if (en && !found_c && req[idx_c]) begin
            found_c        = 1'b1;
            grant_c[idx_c] = 1'b1;
            grant_idx_c    = idx_c;
         end
      end
   end

   // Next search starts just past the last winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (found_c) begin
         ptr_q <= (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
      end
   end

endmodule

// File: rtl/m2s_req_arbiter.sv
// Shares the single VPI memory-access port among NUM_REQ requesters.
// Ports: clk, reset (async, active-high) and bus (slave modport) carrying
// requests/grants, the issued access (access_en, request_out,
// identification_out), VPI responses, per-requester completions, the
// outstanding count, the drain handshake and the orphan-response pulse.
// Each issued access gets an id from a wrapping counter and is remembered in
// a DEPTH-entry tag table so its completion can be routed back.
module m2s_req_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ID_W    = 10
) (
   input  logic               clk,
   input  logic               reset,
   m2s_req_arbiter_if.slave   bus
);

   import m2s_pkg::*;

   localparam int unsigned PTR_W  = $clog2(NUM_REQ);
   localparam int unsigned SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t state_q, state_d;
   logic   run_c, drained_c;

   logic [DEPTH-1:0]   vld_q;
   logic [ID_W-1:0]    tag_id_q  [DEPTH];
   logic [PTR_W-1:0]   tag_req_q [DEPTH];
   logic [ID_W-1:0]    id_cnt_q;

   logic               access_en_q;
   m2s_req_t           request_q;
   logic [ID_W-1:0]    ident_q;
   logic [NUM_REQ-1:0] cmp_valid_q;
   logic [DATA_HI:0]   cmp_data_q;
   logic               orphan_q;
   logic [CNT_W-1:0]   outstanding_q;

   logic               free_hit_c, id_busy_c, hit_c, grant_en_c, fire_c;
   logic [SLOT_W-1:0]  free_idx_c, hit_idx_c;
   logic [NUM_REQ-1:0] grant_c;
   logic [PTR_W-1:0]   grant_idx_c;
   logic [REQ_W-1:0]   req_arr_c [NUM_REQ];
   logic [REQ_W-1:0]   win_req_c;

   // Drain FSM: state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RUN;
      else       state_q <= state_d;
   end

   // Drain FSM: next state. DRAINED needs an empty table and no response in flight.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.drain_req) state_d = DRAIN;
         DRAIN:   if (!bus.drain_req)                               state_d = RUN;
                  else if (outstanding_q == '0 && !bus.resp_valid)  state_d = DRAINED;
         DRAINED: if (!bus.drain_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Drain FSM: state decodes.
   always_comb begin
      run_c     = (state_q == RUN);
      drained_c = (state_q == DRAINED);
   end

   // Table lookups use occupancy from the start of the cycle.
   always_comb begin
      free_hit_c = 1'b0;
      free_idx_c = '0;
      id_busy_c  = 1'b0;
      hit_c      = 1'b0;
      hit_idx_c  = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!vld_q[i] && !free_hit_c) begin
            free_hit_c = 1'b1;
            free_idx_c = SLOT_W'(i);
         end
         if (vld_q[i] && tag_id_q[i] == id_cnt_q) id_busy_c = 1'b1;
         if (bus.resp_valid && vld_q[i] && tag_id_q[i] == bus.resp_id && !hit_c) begin
            hit_c     = 1'b1;
            hit_idx_c = SLOT_W'(i);
         end
      end
   end

   // Unpacked view of the request slices for winner selection.
   always_comb begin
      for (int i = 0; i < int'(NUM_REQ); i++) req_arr_c[i] = bus.req_data[i*REQ_W +: REQ_W];
   end

   // Reset is folded in so req_ready is already low while reset is held.
   assign grant_en_c = run_c && !reset && !bus.mem_busy && free_hit_c && !id_busy_c;
   assign fire_c     = |grant_c;
   assign win_req_c  = req_arr_c[grant_idx_c];

   m2s_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk         (clk),
      .reset       (reset),
      .en          (grant_en_c),
      .req         (bus.req_valid),
      .grant_c     (grant_c),
      .grant_idx_c (grant_idx_c)
   );

   // Issue, tag-table allocation/release and completion routing.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_id_q[i]  <= '0;
            tag_req_q[i] <= '0;
         end
         id_cnt_q      <= '0;
         access_en_q   <= 1'b0;
         request_q     <= '0;
         ident_q       <= '0;
         cmp_valid_q   <= '0;
         cmp_data_q    <= '0;
         orphan_q      <= 1'b0;
         outstanding_q <= '0;
      end else begin
         access_en_q <= fire_c;
         cmp_valid_q <= '0;
         orphan_q    <= bus.resp_valid && !hit_c;
         if (fire_c) begin
            request_q <= '{rw:   win_req_c[RW_BIT],
                           addr: win_req_c[ADDR_HI:ADDR_LO],
                           data: win_req_c[DATA_HI:0]};
            ident_q               <= id_cnt_q;
            id_cnt_q              <= id_cnt_q + ID_W'(1);
            vld_q[free_idx_c]     <= 1'b1;
            tag_id_q[free_idx_c]  <= id_cnt_q;
            tag_req_q[free_idx_c] <= grant_idx_c;
         end
         // The freed slot was valid, the allocated one free: never the same entry.
         if (hit_c) begin
            vld_q[hit_idx_c] <= 1'b0;
            cmp_valid_q      <= NUM_REQ'(1) << tag_req_q[hit_idx_c];
            cmp_data_q       <= bus.resp_data;
         end
         outstanding_q <= outstanding_q + CNT_W'(fire_c) - CNT_W'(hit_c);
      end
   end

   assign bus.req_ready          = grant_c;
   assign bus.access_en          = access_en_q;
   assign bus.request_out        = request_q;
   assign bus.identification_out = ident_q;
   assign bus.cmp_valid          = cmp_valid_q;
   assign bus.cmp_data           = cmp_data_q;
   assign bus.outstanding        = outstanding_q;
   assign bus.drained            = drained_c;
   assign bus.orphan_resp        = orphan_q;

endmodule

// File: tb/tb_m2s_req_arbiter.sv
// Directed test of m2s_req_arbiter (NUM_REQ=4, DEPTH=8, ID_W=10).
module tb_m2s_req_arbiter;

   logic clk;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   m2s_req_arbiter_if #(.NUM_REQ(4), .ID_W(10)) bus ();

   m2s_req_arbiter #(.NUM_REQ(4), .DEPTH(8), .ID_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [9:0] dids [3];
      logic [3:0] downs [3];
      dids  = '{10'd8, 10'd7, 10'd6};
      downs = '{4'b0001, 4'b1000, 4'b0100};

      reset          = 1'b1;
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.mem_busy   = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_id    = '0;
      bus.resp_data  = '0;
      bus.drain_req  = 1'b0;
      #2;
      chk("rst_access_en",   bus.access_en, 0);
      chk("rst_outstanding", bus.outstanding, 0);
      chk("rst_req_ready",   bus.req_ready, 0);
      chk("rst_request_out", bus.request_out, 0);
      chk("rst_ident",       bus.identification_out, 0);
      chk("rst_cmp_valid",   bus.cmp_valid, 0);
      chk("rst_drained",     bus.drained, 0);
      chk("rst_orphan",      bus.orphan_resp, 0);
      tick();
      tick();
      reset = 1'b0;

      // Single request from requester 0.
      bus.req_data[63:0] = 64'h8000_0010_DEAD_BEEF;
      bus.req_valid      = 4'b0001;
      #1;
      chk("t1_req_ready", bus.req_ready, 4'b0001);
      tick();
      bus.req_valid = '0;
      chk("t1_access_en",   bus.access_en, 1);
      chk("t1_request_out", bus.request_out, 64'h8000_0010_DEAD_BEEF);
      chk("t1_ident",       bus.identification_out, 0);
      chk("t1_outstanding", bus.outstanding, 1);
      tick();
      chk("t1_access_pulse", bus.access_en, 0);
      chk("t1_request_hold", bus.request_out, 64'h8000_0010_DEAD_BEEF);
      bus.resp_valid = 1'b1;
      bus.resp_id    = 10'd0;
      bus.resp_data  = 32'hCAFE_0000;
      tick();
      bus.resp_valid = 1'b0;
      chk("t1_cmp_valid",    bus.cmp_valid, 4'b0001);
      chk("t1_cmp_data",     bus.cmp_data, 32'hCAFE_0000);
      chk("t1_outstanding0", bus.outstanding, 0);

      // Fresh start, then all four requesters fill the table.
      reset = 1'b1;
      #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) bus.req_data[i*64 +: 64] = 64'hA000_0000_0000_0000 | 64'(i);
      bus.req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("t2_ready_%0d", k), bus.req_ready, 64'(1) << (k % 4));
         tick();
         chk($sformatf("t2_access_%0d", k), bus.access_en, 1);
         chk($sformatf("t2_id_%0d", k), bus.identification_out, 64'(k));
         chk($sformatf("t2_req_%0d", k), bus.request_out, 64'hA000_0000_0000_0000 | 64'(k % 4));
      end
      #1;
      chk("t2_full_ready",       bus.req_ready, 0);
      chk("t2_full_outstanding", bus.outstanding, 8);
      tick();
      chk("t2_full_access", bus.access_en, 0);

      // Complete id 5 (requester 1); the freed slot is reused by id 8.
      bus.resp_valid = 1'b1;
      bus.resp_id    = 10'd5;
      bus.resp_data  = 32'h1234_5678;
      #1;
      chk("t3_ready_full", bus.req_ready, 0);
      tick();
      bus.resp_valid = 1'b0;
      chk("t3_cmp_valid",   bus.cmp_valid, 4'b0010);
      chk("t3_cmp_data",    bus.cmp_data, 32'h1234_5678);
      chk("t3_outstanding", bus.outstanding, 7);
      #1;
      chk("t3_ready", bus.req_ready, 4'b0001);
      tick();
      chk("t3_access",      bus.access_en, 1);
      chk("t3_id",          bus.identification_out, 8);
      chk("t3_req",         bus.request_out, 64'hA000_0000_0000_0000);
      chk("t3_outstanding8", bus.outstanding, 8);
      #1;
      chk("t3_refull_ready", bus.req_ready, 0);
      bus.req_valid = '0;

      // Unknown id 700.
      bus.resp_valid = 1'b1;
      bus.resp_id    = 10'd700;
      tick();
      bus.resp_valid = 1'b0;
      chk("t4_orphan",      bus.orphan_resp, 1);
      chk("t4_outstanding", bus.outstanding, 8);
      chk("t4_cmp_valid",   bus.cmp_valid, 0);
      tick();
      chk("t4_orphan_pulse", bus.orphan_resp, 0);

      // Retire ids 0..4, leaving 6, 7, 8 outstanding; then drain.
      for (int k = 0; k < 5; k++) begin
         bus.resp_valid = 1'b1;
         bus.resp_id    = 10'(k);
         bus.resp_data  = 32'h5000_0000 | 32'(k);
         tick();
         chk($sformatf("t5_cmp_%0d", k), bus.cmp_valid, 64'(1) << (k % 4));
      end
      bus.resp_valid = 1'b0;
      chk("t5_outstanding3", bus.outstanding, 3);
      bus.drain_req = 1'b1;
      tick();
      bus.req_valid = 4'hF;
      #1;
      chk("t5_drain_ready", bus.req_ready, 0);
      for (int j = 0; j < 3; j++) begin
         bus.resp_valid = 1'b1;
         bus.resp_id    = dids[j];
         tick();
         chk($sformatf("t5_drain_cmp_%0d", j), bus.cmp_valid, 64'(downs[j]));
         chk($sformatf("t5_drain_access_%0d", j), bus.access_en, 0);
         chk($sformatf("t5_not_drained_%0d", j), bus.drained, 0);
      end
      bus.resp_valid = 1'b0;
      tick();
      chk("t5_drained",      bus.drained, 1);
      chk("t5_outstanding0", bus.outstanding, 0);
      bus.drain_req = 1'b0;
      #1;
      chk("t5_drained_ready", bus.req_ready, 0);
      tick();
      chk("t5_run", bus.drained, 0);
      #1;
      chk("t5_resume_ready", bus.req_ready, 4'b0010);
      tick();
      chk("t5_resume_access", bus.access_en, 1);
      chk("t5_resume_id",     bus.identification_out, 9);
      chk("t5_resume_req",    bus.request_out, 64'hA000_0000_0000_0001);
      bus.req_valid = '0;

      // mem_busy blocks grants but not an already registered pulse.
      bus.req_valid = 4'b0001;
      bus.mem_busy  = 1'b1;
      #1;
      chk("t6_busy_ready", bus.req_ready, 0);
      tick();
      chk("t6_busy_access", bus.access_en, 0);
      bus.mem_busy = 1'b0;
      #1;
      chk("t6_ready", bus.req_ready, 4'b0001);
      tick();
      bus.mem_busy = 1'b1;
      #1;
      chk("t6_pulse_under_busy", bus.access_en, 1);
      chk("t6_id",               bus.identification_out, 10);
      tick();
      chk("t6_pulse_end", bus.access_en, 0);
      bus.mem_busy  = 1'b0;
      bus.req_valid = '0;

      // Reset in the middle of a burst.
      bus.req_valid = 4'hF;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("t7_access_en",   bus.access_en, 0);
      chk("t7_outstanding", bus.outstanding, 0);
      chk("t7_req_ready",   bus.req_ready, 0);
      chk("t7_request_out", bus.request_out, 0);
      chk("t7_ident",       bus.identification_out, 0);
      chk("t7_cmp_valid",   bus.cmp_valid, 0);
      bus.req_valid = '0;
      reset = 1'b0;
      bus.resp_valid = 1'b1;
      bus.resp_id    = 10'd9;
      tick();
      bus.resp_valid = 1'b0;
      chk("t7_orphan",       bus.orphan_resp, 1);
      chk("t7_outstanding0", bus.outstanding, 0);

      // Hold id 0, cycle the counter through 1..1023, stall at the wrap.
      bus.req_data[63:0]   = 64'h0000_0001_0000_0000;
      bus.req_data[127:64] = 64'h8000_0002_0000_0001;
      bus.req_valid = 4'b0001;
      tick();
      chk("t8_id0", bus.identification_out, 0);
      bus.req_valid = 4'b0010;
      for (int k = 1; k < 1024; k++) begin
         tick();
         chk($sformatf("t8_id_%0d", k), bus.identification_out, 64'(k));
         bus.resp_valid = 1'b1;
         bus.resp_id    = 10'(k);
      end
      #1;
      chk("t8_wrap_stall_ready", bus.req_ready, 0);
      tick();
      bus.resp_valid = 1'b0;
      chk("t8_last_cmp",  bus.cmp_valid, 4'b0010);
      chk("t8_stall_acc", bus.access_en, 0);
      #1;
      chk("t8_stall_ready2", bus.req_ready, 0);
      tick();
      chk("t8_stall_acc2",     bus.access_en, 0);
      chk("t8_outstanding1",   bus.outstanding, 1);
      bus.resp_valid = 1'b1;
      bus.resp_id    = 10'd0;
      tick();
      bus.resp_valid = 1'b0;
      chk("t8_id0_cmp",      bus.cmp_valid, 4'b0001);
      chk("t8_outstanding0", bus.outstanding, 0);
      #1;
      chk("t8_resume_ready", bus.req_ready, 4'b0010);
      tick();
      chk("t8_reissue_access", bus.access_en, 1);
      chk("t8_reissue_id0",    bus.identification_out, 0);
      bus.req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
